// File: rtl/bru_if.sv
// Fetch/EX/BHT-write signal bundle for the branch resolution unit.
// The slave modport is the unit; the master is whoever drives fetch, EX and the BHT side.
interface bru_if #(
    parameter int LOWER = 5,
    parameter int CNT_W = 16
);
    logic             en;
    logic             fetch_valid;
    logic [LOWER-1:0] fetch_addr;
    logic             fetch_pred;
    logic             fetch_ready;
    logic             res_valid;
    logic             res_taken;
    logic             res_jumped;
    logic             res_ready;
    logic             upd_valid;
    logic [LOWER-1:0] upd_addr;
    logic             upd_taken;
    logic             upd_ready;
    logic             flush;
    logic             empty;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    modport slave (
        input  en, fetch_valid, fetch_addr, fetch_pred, res_valid, res_taken, res_jumped, upd_ready,
        output fetch_ready, res_ready, upd_valid, upd_addr, upd_taken, flush, empty,
               branch_cnt, mispred_cnt
    );

    modport master (
        output en, fetch_valid, fetch_addr, fetch_pred, res_valid, res_taken, res_jumped, upd_ready,
        input  fetch_ready, res_ready, upd_valid, upd_addr, upd_taken, flush, empty,
               branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_resolution_unit.sv
// Pairs in-flight fetch predictions with in-order EX outcomes and drives BHT updates.
// A mispredict pulses flush for one cycle and drops all younger wrong-path entries.
//
//   state  | meaning
//   S_IDLE | no BHT update pending (upd_valid=0)
//   S_PEND | update held on upd_addr/upd_taken until upd_ready
module branch_resolution_unit #(
    parameter int LOWER = 5,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic  clk,
    input  logic  arst_n,
    bru_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {S_IDLE, S_PEND} upd_state_t;

    upd_state_t       r_state;
    logic [LOWER-1:0] r_mem_addr [DEPTH];
    logic [DEPTH-1:0] r_mem_pred;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             r_upd_valid;
    logic [LOWER-1:0] r_upd_addr;
    logic             r_upd_taken;
    logic             r_flush;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic w_full;
    logic w_empty;
    logic w_enq;
    logic w_res_ready;
    logic w_acc;
    logic w_outcome;
    logic w_mispred;

    assign w_full      = (r_count == (PW+1)'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_enq       = bus.en & bus.fetch_valid & ~w_full;
    assign w_res_ready = bus.en & ~w_empty & (~r_upd_valid | bus.upd_ready);
    assign w_acc       = bus.res_valid & w_res_ready;
    assign w_outcome   = bus.res_taken | bus.res_jumped;
    assign w_mispred   = w_acc & (w_outcome != r_mem_pred[r_rd_ptr]);

    assign bus.fetch_ready = ~w_full;
    assign bus.res_ready   = w_res_ready;
    assign bus.empty       = w_empty;
    assign bus.upd_valid   = r_upd_valid;
    assign bus.upd_addr    = r_upd_addr;
    assign bus.upd_taken   = r_upd_taken;
    assign bus.flush       = r_flush;
    assign bus.branch_cnt  = r_branch_cnt;
    assign bus.mispred_cnt = r_mispred_cnt;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_mem_pred <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem_addr[i] <= '0;
        end else if (w_mispred) begin
            // Everything younger than the head is wrong-path, including this cycle's fetch.
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_wr_ptr <= r_rd_ptr + 1'b1;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_mem_addr[r_wr_ptr] <= bus.fetch_addr;
                r_mem_pred[r_wr_ptr] <= bus.fetch_pred;
                r_wr_ptr             <= r_wr_ptr + 1'b1;
            end
            if (w_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_enq, w_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state     <= S_IDLE;
            r_upd_valid <= 1'b0;
            r_upd_addr  <= '0;
            r_upd_taken <= 1'b0;
            r_flush     <= 1'b0;
        end else begin
            r_flush <= w_mispred;
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_state     <= S_PEND;
                        r_upd_valid <= 1'b1;
                        r_upd_addr  <= r_mem_addr[r_rd_ptr];
                        r_upd_taken <= w_outcome;
                    end
                end
                S_PEND: begin
                    if (w_acc) begin
                        r_upd_addr  <= r_mem_addr[r_rd_ptr];
                        r_upd_taken <= w_outcome;
                    end else if (bus.upd_ready) begin
                        r_state     <= S_IDLE;
                        r_upd_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_upd_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (w_acc) begin
            if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + 1'b1;
            if (w_mispred && (r_mispred_cnt != '1)) r_mispred_cnt <= r_mispred_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed bench: stimulus pushes hand-computed expected updates, a monitor pops them as updates appear.
// A second CNT_W=2 instance shares the stimulus to exercise counter saturation.
module tb_branch_resolution_unit;
    logic       clk = 1'b0;
    logic       arst_n;
    logic       en, fetch_valid, fetch_pred, res_valid, res_taken, res_jumped, upd_ready;
    logic [4:0] fetch_addr;

    bru_if #(.LOWER(5), .CNT_W(16)) bi ();
    bru_if #(.LOWER(5), .CNT_W(2))  bs ();

    assign bi.en = en;            assign bs.en = en;
    assign bi.fetch_valid = fetch_valid; assign bs.fetch_valid = fetch_valid;
    assign bi.fetch_addr = fetch_addr;   assign bs.fetch_addr = fetch_addr;
    assign bi.fetch_pred = fetch_pred;   assign bs.fetch_pred = fetch_pred;
    assign bi.res_valid = res_valid;     assign bs.res_valid = res_valid;
    assign bi.res_taken = res_taken;     assign bs.res_taken = res_taken;
    assign bi.res_jumped = res_jumped;   assign bs.res_jumped = res_jumped;
    assign bi.upd_ready = upd_ready;     assign bs.upd_ready = upd_ready;

    branch_resolution_unit #(.LOWER(5), .DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .arst_n(arst_n), .bus(bi));
    branch_resolution_unit #(.LOWER(5), .DEPTH(4), .CNT_W(2)) dut_sat (
        .clk(clk), .arst_n(arst_n), .bus(bs));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  addr;
        logic        taken;
        logic        flush;
        logic [15:0] bc;
        logic [15:0] mc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic prev_v = 1'b0;
    logic prev_hs = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A new update is presented when upd_valid rises or reloads right after a handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!arst_n) begin
            prev_v  = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (bi.upd_valid && (!prev_v || prev_hs)) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL upd_unexpected: got addr %0h with no expected entry", bi.upd_addr);
                end else begin
                    e = sb.pop_front();
                    chk("upd_addr",    32'(bi.upd_addr),    32'(e.addr));
                    chk("upd_taken",   32'(bi.upd_taken),   32'(e.taken));
                    chk("flush",       32'(bi.flush),       32'(e.flush));
                    chk("branch_cnt",  32'(bi.branch_cnt),  32'(e.bc));
                    chk("mispred_cnt", 32'(bi.mispred_cnt), 32'(e.mc));
                end
            end
            prev_v  = bi.upd_valid;
            prev_hs = bi.upd_valid & bi.upd_ready;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [4:0] a, input logic p);
        fetch_valid = 1'b1;
        fetch_addr  = a;
        fetch_pred  = p;
        step();
        fetch_valid = 1'b0;
    endtask

    task automatic resolve(input logic t, input logic j, input logic [4:0] ea, input logic et,
                           input logic ef, input logic [15:0] eb, input logic [15:0] em);
        bit got = 0;
        res_valid  = 1'b1;
        res_taken  = t;
        res_jumped = j;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bi.res_ready) got = 1;
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL res_ready_timeout: got 0 expected 1 within 20 cycles");
            res_valid = 1'b0;
        end else begin
            sb.push_back('{addr: ea, taken: et, flush: ef, bc: eb, mc: em});
            step();
            res_valid = 1'b0;
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_upd_valid",   32'(bi.upd_valid),   0);
        chk("rst_upd_addr",    32'(bi.upd_addr),    0);
        chk("rst_upd_taken",   32'(bi.upd_taken),   0);
        chk("rst_flush",       32'(bi.flush),       0);
        chk("rst_empty",       32'(bi.empty),       1);
        chk("rst_fetch_ready", 32'(bi.fetch_ready), 1);
        chk("rst_res_ready",   32'(bi.res_ready),   0);
        chk("rst_branch_cnt",  32'(bi.branch_cnt),  0);
        chk("rst_mispred_cnt", 32'(bi.mispred_cnt), 0);
        chk("rst_sat_mispred", 32'(bs.mispred_cnt), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_n = 1'b0; en = 1'b1; fetch_valid = 1'b0; fetch_addr = '0; fetch_pred = 1'b0;
        res_valid = 1'b0; res_taken = 1'b0; res_jumped = 1'b0; upd_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs();
        step();
        arst_n = 1'b1;

        // correct taken prediction
        enq(5'd3, 1'b1);
        resolve(1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 16'd1, 16'd0);

        // fill to DEPTH, extra fetch refused, pop frees a slot
        enq(5'd4, 1'b1); enq(5'd5, 1'b1); enq(5'd6, 1'b1); enq(5'd7, 1'b1);
        @(negedge clk);
        chk("full_fetch_ready", 32'(bi.fetch_ready), 0);
        step();
        enq(5'd8, 1'b0);
        resolve(1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 16'd2, 16'd0);
        @(negedge clk);
        chk("pop_fetch_ready", 32'(bi.fetch_ready), 1);
        step();
        resolve(1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 16'd3, 16'd0);
        resolve(1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 16'd4, 16'd0);
        resolve(1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 16'd5, 16'd0);
        @(negedge clk);
        chk("drained_empty", 32'(bi.empty), 1);
        step();

        // mispredict discards younger entries
        enq(5'd1, 1'b0); enq(5'd2, 1'b0); enq(5'd3, 1'b0);
        resolve(1'b1, 1'b0, 5'd1, 1'b1, 1'b1, 16'd6, 16'd1);
        @(negedge clk);
        chk("flush_empty",     32'(bi.empty),     1);
        chk("flush_res_ready", 32'(bi.res_ready), 0);
        step();
        @(negedge clk);
        chk("flush_one_cycle", 32'(bi.flush), 0);
        step();

        // BHT backpressure blocks resolution, then reload on handshake
        enq(5'd9, 1'b1); enq(5'd10, 1'b0);
        resolve(1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 16'd7, 16'd1);
        upd_ready = 1'b0; res_valid = 1'b1; res_taken = 1'b0; res_jumped = 1'b0;
        @(negedge clk);
        chk("bp_res_ready", 32'(bi.res_ready), 0);
        chk("bp_upd_valid", 32'(bi.upd_valid), 1);
        step();
        @(negedge clk);
        chk("bp_res_ready2", 32'(bi.res_ready), 0);
        chk("bp_addr_hold",  32'(bi.upd_addr),  9);
        chk("bp_taken_hold", 32'(bi.upd_taken), 1);
        step();
        upd_ready = 1'b1;
        resolve(1'b0, 1'b0, 5'd10, 1'b0, 1'b0, 16'd8, 16'd1);

        // unconditional jump counts as taken; en=0 freezes resolution
        enq(5'd11, 1'b1);
        resolve(1'b0, 1'b1, 5'd11, 1'b1, 1'b0, 16'd9, 16'd1);
        enq(5'd12, 1'b1);
        en = 1'b0; res_valid = 1'b1; res_taken = 1'b1;
        @(negedge clk);
        chk("en0_res_ready", 32'(bi.res_ready), 0);
        step();
        @(negedge clk);
        chk("en0_branch_cnt", 32'(bi.branch_cnt), 9);
        chk("en0_not_empty",  32'(bi.empty),      0);
        step();
        en = 1'b1;
        resolve(1'b1, 1'b0, 5'd12, 1'b1, 1'b0, 16'd10, 16'd1);

        // repeated mispredicts saturate the 2-bit counters
        enq(5'd13, 1'b1);
        resolve(1'b0, 1'b0, 5'd13, 1'b0, 1'b1, 16'd11, 16'd2);
        enq(5'd14, 1'b0);
        resolve(1'b1, 1'b0, 5'd14, 1'b1, 1'b1, 16'd12, 16'd3);
        enq(5'd15, 1'b1);
        resolve(1'b0, 1'b0, 5'd15, 1'b0, 1'b1, 16'd13, 16'd4);
        @(negedge clk);
        chk("sat_mispred_cnt", 32'(bs.mispred_cnt), 3);
        chk("sat_branch_cnt",  32'(bs.branch_cnt),  3);
        step();

        // reset with entries in flight and an update pending
        enq(5'd16, 1'b1); enq(5'd17, 1'b0);
        res_valid = 1'b1; res_taken = 1'b1;
        step();
        res_valid = 1'b0;
        arst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        step();
        arst_n = 1'b1;

        enq(5'd2, 1'b1);
        resolve(1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 16'd1, 16'd0);
        repeat (3) step();
        chk("scoreboard_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
